// File: rtl/ring_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ring_freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/osc_edge_sync.sv
// Brings one asynchronous divided-oscillator line into the clk domain and
// emits a single-cycle pulse on each rising edge.
module osc_edge_sync
    import ring_freq_meter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign edge_out = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/ring_freq_meter.sv
// Multi-channel frequency meter: counts rising edges of the selected
// oscillator over a gate window of G clk cycles and reports the total.
module ring_freq_meter
    import ring_freq_meter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] osc_in,
    input  logic              start,
    input  logic              continuous,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int SEL_SPAN = 1 << SEL_W;

    // Selector codes beyond NUM_CH map onto tied-off lanes, so a bad
    // select simply sees no edges.
    logic [SEL_SPAN-1:0] edge_vec;

    genvar gi;
    generate
        for (gi = 0; gi < SEL_SPAN; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_sync
                osc_edge_sync u_sync (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .async_in (osc_in[gi]),
                    .edge_out (edge_vec[gi])
                );
            end else begin : g_pad
                assign edge_vec[gi] = 1'b0;
            end
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg;
    logic [GATE_W-1:0]  gate_cnt_reg;
    logic [CNT_W-1:0]   edge_cnt_reg;
    logic               sat_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg;

    logic               launch;
    logic               gate_zero;
    logic               edge_sel;
    logic               at_max;
    logic               last_gate;
    logic [CNT_W-1:0]   edge_cnt_next;
    logic               sat_next;

    assign launch        = ((state_reg == IDLE) && start) ||
                           ((state_reg == DONE) && continuous);
    assign gate_zero     = (gate_cycles == '0);
    assign edge_sel      = edge_vec[sel_reg];
    assign at_max        = &edge_cnt_reg;
    assign last_gate     = (state_reg == GATE) && (gate_cnt_reg == GATE_W'(1));
    assign edge_cnt_next = (edge_sel && !at_max) ? edge_cnt_reg + 1'b1 : edge_cnt_reg;
    assign sat_next      = sat_reg | (edge_sel & at_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = gate_zero ? DONE : GATE;
            GATE: if (gate_cnt_reg == GATE_W'(1)) state_next = DONE;
            DONE: begin
                if (continuous) state_next = gate_zero ? DONE : GATE;
                else            state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == GATE);
        done = (state_reg == DONE);
    end

    // Result registers load on entry to DONE so they are valid with the pulse
    // and stay untouched while the next window accumulates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg      <= '0;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (launch) begin
            sel_reg      <= ch_sel;
            gate_cnt_reg <= gate_cycles;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
            if (gate_zero) begin
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end
        end else if (state_reg == GATE) begin
            gate_cnt_reg <= gate_cnt_reg - 1'b1;
            edge_cnt_reg <= edge_cnt_next;
            sat_reg      <= sat_next;
            if (last_gate) begin
                count_reg    <= edge_cnt_next;
                overflow_reg <= sat_next;
            end
        end
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Scoreboard bench for ring_freq_meter: a 4-channel/16-bit instance and a
// 3-channel/4-bit instance (saturation and out-of-range select).
module tb_ring_freq_meter;

    typedef struct {
        int lo;
        int hi;
        bit ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  osc;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  ch_sel = '0;
    logic [15:0] gate_cycles = '0;
    logic        busy, done, ovf;
    logic [15:0] count;

    logic [2:0]  osc_s;
    logic        start_s = 1'b0;
    logic [1:0]  ch_sel_s = '0;
    logic [15:0] gate_s = '0;
    logic        busy_s, done_s, ovf_s;
    logic [3:0]  count_s;

    logic [6:0]  osc_v;
    int          half [7];
    int          tnow = 0;

    exp_t q_m[$];
    exp_t q_s[$];
    int checks = 0;
    int failures = 0;

    assign osc   = osc_v[3:0];
    assign osc_s = osc_v[6:4];

    always #5 clk = ~clk;

    ring_freq_meter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .osc_in      (osc),
        .start       (start),
        .continuous  (continuous),
        .ch_sel      (ch_sel),
        .gate_cycles (gate_cycles),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .overflow    (ovf)
    );

    ring_freq_meter #(.NUM_CH(3), .CNT_W(4)) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .osc_in      (osc_s),
        .start       (start_s),
        .continuous  (1'b0),
        .ch_sel      (ch_sel_s),
        .gate_cycles (gate_s),
        .busy        (busy_s),
        .done        (done_s),
        .count       (count_s),
        .overflow    (ovf_s)
    );

    // Free-running oscillators; half[c] is the half period in time units
    // (clk period is 10), zero means the line is held low.
    initial begin
        for (int c = 0; c < 7; c++) half[c] = 0;
        osc_v = '0;
        forever begin
            #1;
            tnow++;
            for (int c = 0; c < 7; c++) begin
                if (half[c] == 0) osc_v[c] = 1'b0;
                else if (((tnow + c * 3) % half[c]) == 0) osc_v[c] = ~osc_v[c];
            end
        end
    end

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s actual=%0d", name, act);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s actual=%0d", name, act);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q_m.size() == 0) chk("main_unexpected_done", 1'b0, 1, 0);
            else begin
                e = q_m.pop_front();
                chk_range("main_count", int'(count), e.lo, e.hi);
                chk("main_overflow", ovf == e.ovf, int'(ovf), int'(e.ovf));
            end
        end
        if (done_s === 1'b1) begin
            if (q_s.size() == 0) chk("small_unexpected_done", 1'b0, 1, 0);
            else begin
                e = q_s.pop_front();
                chk_range("small_count", int'(count_s), e.lo, e.hi);
                chk("small_overflow", ovf_s == e.ovf, int'(ovf_s), int'(e.ovf));
            end
        end
    end

    // Called on a negedge; start is sampled on the following posedge (cycle T).
    task automatic launch(input bit sdut, input int sel, input int g,
                          input int lo, input int hi, input bit ovf_e);
        exp_t e;
        e.lo = lo; e.hi = hi; e.ovf = ovf_e;
        if (sdut) begin
            q_s.push_back(e);
            ch_sel_s = sel[1:0]; gate_s = g[15:0]; start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0;
        end else begin
            q_m.push_back(e);
            ch_sel = sel[1:0]; gate_cycles = g[15:0]; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Counts cycles until done and busy cycles seen on the way; both must be G.
    task automatic run_window(input bit sdut, input int g, input string tag);
        int k = 0;
        int nb = 0;
        while (k <= 5000) begin
            if ((sdut ? done_s : done) === 1'b1) break;
            if ((sdut ? busy_s : busy) === 1'b1) nb++;
            k++;
            @(negedge clk);
        end
        chk({tag, "_done_latency"}, k == g, k, g);
        chk({tag, "_busy_cycles"}, nb == g, nb, g);
    endtask

    initial begin
        exp_t e;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy == 1'b0, int'(busy), 0);
        chk("reset_done", done == 1'b0, int'(done), 0);
        chk("reset_count", count == 16'd0, int'(count), 0);
        chk("reset_overflow", ovf == 1'b0, int'(ovf), 0);
        rst_n = 1'b1;
        half[1] = 50;
        repeat (10) @(negedge clk);

        // Reset mid-window: abort with no done afterwards.
        ch_sel = 2'd1; gate_cycles = 16'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("midwin_busy_before_reset", busy == 1'b1, int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midwin_reset_busy", busy == 1'b0, int'(busy), 0);
        chk("midwin_reset_done", done == 1'b0, int'(done), 0);
        chk("midwin_reset_count", count == 16'd0, int'(count), 0);
        chk("midwin_reset_overflow", ovf == 1'b0, int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (130) @(negedge clk);
        chk("after_abort_idle", busy == 1'b0, int'(busy), 0);

        // Basic window: ch1 period 10, G=100.
        launch(1'b0, 1, 100, 9, 11, 1'b0);
        run_window(1'b0, 100, "basic");
        @(negedge clk);

        // Channel isolation: ch0 period 4, ch2 period 20.
        half[0] = 20; half[2] = 100;
        repeat (10) @(negedge clk);
        launch(1'b0, 2, 200, 9, 11, 1'b0);
        chk_range("count_held_next_window", int'(count), 9, 11);
        run_window(1'b0, 200, "iso_ch2");
        @(negedge clk);
        launch(1'b0, 0, 200, 49, 51, 1'b0);
        run_window(1'b0, 200, "iso_ch0");
        @(negedge clk);

        // Zero gate: done at T+1, busy never asserted.
        launch(1'b0, 1, 0, 0, 0, 1'b0);
        run_window(1'b0, 0, "zero_gate");
        @(negedge clk);

        // Continuous mode, ignored start, then mode drop after the third window.
        half[1] = 30;
        repeat (10) @(negedge clk);
        continuous = 1'b1;
        e.lo = 4; e.hi = 6; e.ovf = 1'b0;
        q_m.push_back(e);
        q_m.push_back(e);
        launch(1'b0, 1, 30, 4, 6, 1'b0);
        run_window(1'b0, 30, "cont_w1");
        @(negedge clk);
        fork
            run_window(1'b0, 30, "cont_w2");
            begin
                repeat (10) @(negedge clk);
                ch_sel = 2'd0; gate_cycles = 16'd5; start = 1'b1;
                @(negedge clk);
                start = 1'b0; ch_sel = 2'd1; gate_cycles = 16'd30;
            end
        join
        @(negedge clk);
        fork
            run_window(1'b0, 30, "cont_w3");
            begin
                repeat (10) @(negedge clk);
                continuous = 1'b0;
            end
        join
        repeat (60) @(negedge clk);
        chk("cont_drop_idle", busy == 1'b0, int'(busy), 0);
        chk("cont_queue_drained", q_m.size() == 0, q_m.size(), 0);

        // Small instance: saturation, recovery, out-of-range select.
        half[4] = 20; half[5] = 50; half[6] = 30;
        repeat (10) @(negedge clk);
        launch(1'b1, 0, 200, 15, 15, 1'b1);
        run_window(1'b1, 200, "sat");
        @(negedge clk);
        launch(1'b1, 0, 20, 4, 6, 1'b0);
        run_window(1'b1, 20, "sat_recover");
        @(negedge clk);
        launch(1'b1, 3, 50, 0, 0, 1'b0);
        run_window(1'b1, 50, "bad_sel");
        repeat (5) @(negedge clk);
        chk("small_queue_drained", q_s.size() == 0, q_s.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
